// File: rtl/task10_storage_if.sv
// Board-side bus of the register-file storage block: key, switches and LED readback.
interface task10_storage_if;
    logic       key1_write;
    logic [2:0] sw_addr;
    logic [7:0] sw_value;
    logic [7:0] ledr_indic;

    modport master (output key1_write, output sw_addr, output sw_value, input ledr_indic);
    modport slave  (input key1_write, input sw_addr, input sw_value, output ledr_indic);
endinterface

// File: rtl/task10_storage.sv
// 8x8 register file written from switches on a key press, continuously displayed on LEDs.
module task10_storage (
    input  logic             clk,
    input  logic             key0_rst,
    task10_storage_if.slave  bus
);
    logic       key_s1, key_s2, k3;
    logic [2:0] addr_s1, addr_s2;
    logic [7:0] value_s1, value_s2;
    logic [7:0] mem [8];
    logic [7:0] ledr_q;
    logic       strobe;

    // Released-to-pressed edge of the synchronized, active-low key.
    assign strobe = !key_s2 && k3;

    assign bus.ledr_indic = ledr_q;

    // NOTE: non-blocking assignments keep every stage sampling its predecessor's
    // pre-edge value, which is what makes the chain a true two-flop synchronizer.
    always_ff @(posedge clk) begin
        if (key0_rst) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            k3       <= 1'b1;
            addr_s1  <= '0;
            addr_s2  <= '0;
            value_s1 <= '0;
            value_s2 <= '0;
            ledr_q   <= '0;
            // NOTE: the storage must read back as zero after reset, so it lives in
            // flops rather than a RAM macro and every entry is cleared here.
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            key_s1   <= bus.key1_write;
            key_s2   <= key_s1;
            k3       <= key_s2;
            addr_s1  <= bus.sw_addr;
            addr_s2  <= addr_s1;
            value_s1 <= bus.sw_value;
            value_s2 <= value_s1;
            if (strobe) mem[addr_s2] <= value_s2;
            // Write-first: the strobe always targets addr_s2, the displayed location.
            ledr_q <= strobe ? value_s2 : mem[addr_s2];
        end
    end
endmodule

// File: tb/tb_task10_storage.sv
// Self-checking bench: directed board scenarios plus random presses/reads against an array model.
module tb_task10_storage;
    logic clk = 1'b0;
    logic key0_rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [7:0] model [8];

    task10_storage_if bus ();

    task10_storage dut (
        .clk      (clk),
        .key0_rst (key0_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Switches settle, key held low for 'hold' cycles, then released and switches kept until stored.
    task automatic press(input logic [2:0] a, input logic [7:0] v, input int hold);
        bus.sw_addr  = a;
        bus.sw_value = v;
        idle(3);
        bus.key1_write = 1'b0;
        idle(hold);
        bus.key1_write = 1'b1;
        idle(3);
        model[a] = v;
    endtask

    task automatic read(input logic [2:0] a, input string tag);
        bus.sw_addr = a;
        idle(3);
        check(tag, bus.ledr_indic, model[a]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        key0_rst       = 1'b1;
        bus.key1_write = 1'b1;
        bus.sw_addr    = 3'd0;
        bus.sw_value   = 8'h00;

        // LEDs read zero throughout reset for every address.
        idle(2);
        for (int i = 0; i < 8; i++) begin
            bus.sw_addr = 3'(i);
            idle(1);
            check("reset_led", bus.ledr_indic, 8'h00);
        end
        key0_rst = 1'b0;
        idle(2);
        for (int i = 0; i < 8; i++) read(3'(i), "post_reset_read");

        // Reset arriving mid-press must block the write.
        bus.sw_addr  = 3'd3;
        bus.sw_value = 8'h77;
        idle(3);
        bus.key1_write = 1'b0;
        idle(1);
        key0_rst = 1'b1;
        idle(3);
        bus.key1_write = 1'b1;
        idle(3);
        key0_rst = 1'b0;
        idle(2);
        for (int i = 0; i < 8; i++) read(3'(i), "reset_mid_press");

        // Single press, then sequential presses with released key on addr 0 / value 0.
        press(3'd0, 8'd10, 2);
        bus.sw_addr = 3'd5;
        idle(3);
        read(3'd0, "first_write");
        for (int i = 0; i < 5; i++) begin
            press(3'(i), 8'((i + 1) * 10), 3);
            bus.sw_addr  = 3'd0;
            bus.sw_value = 8'h00;
            idle(4);
        end
        for (int i = 1; i < 8; i++) read(3'(i), "sweep");
        read(3'd0, "sweep_addr0");
        check("addr0_kept_10", model[0], 8'd10);

        // Long hold on addr 6 with the value changing mid-hold: one write of 0x55 only.
        bus.sw_addr  = 3'd6;
        bus.sw_value = 8'h55;
        idle(3);
        bus.key1_write = 1'b0;
        idle(3);
        check("hold_first_write", bus.ledr_indic, 8'h55);
        for (int c = 3; c < 20; c++) begin
            if (c == 8) bus.sw_value = 8'hAA;
            idle(1);
            check("hold_no_rewrite", bus.ledr_indic, 8'h55);
        end
        bus.key1_write = 1'b1;
        for (int c = 0; c < 5; c++) begin
            idle(1);
            check("release_no_write", bus.ledr_indic, 8'h55);
        end
        model[6] = 8'h55;
        bus.sw_addr = 3'd0;
        idle(3);
        read(3'd6, "hold_readback");

        // Write-first display: 30 until the write edge, then 0xFF with nothing in between.
        bus.sw_addr = 3'd2;
        idle(3);
        check("wf_before", bus.ledr_indic, 8'd30);
        bus.sw_value = 8'hFF;
        idle(3);
        check("wf_value_settle", bus.ledr_indic, 8'd30);
        bus.key1_write = 1'b0;
        idle(1);
        check("wf_edge1", bus.ledr_indic, 8'd30);
        idle(1);
        check("wf_edge2", bus.ledr_indic, 8'd30);
        idle(1);
        check("wf_edge3", bus.ledr_indic, 8'hFF);
        bus.key1_write = 1'b1;
        idle(3);
        model[2] = 8'hFF;
        read(3'd2, "wf_readback");

        // Write 0xFF to addr 7, then a one-cycle reset clears everything.
        press(3'd7, 8'hFF, 2);
        read(3'd7, "addr7_written");
        key0_rst = 1'b1;
        idle(1);
        check("reset_pulse_led", bus.ledr_indic, 8'h00);
        key0_rst = 1'b0;
        clear_model();
        idle(2);
        for (int i = 0; i < 8; i++) read(3'(i), "after_reset_pulse");

        // Random presses and reads; switches wander while the key is released.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                press(3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)),
                      int'($urandom_range(6, 2)));
                bus.sw_value = 8'($urandom_range(255, 0));
                bus.sw_addr  = 3'($urandom_range(7, 0));
                idle(int'($urandom_range(4, 1)));
            end else begin
                read(3'($urandom_range(7, 0)), "rand_read");
            end
        end
        for (int i = 0; i < 8; i++) read(3'(i), "final_sweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/task10_storage.md
# task10_storage

8-entry × 8-bit register-file storage block driven by board controls. An 8-bit value from switches is written to one of eight locations, selected by a 3-bit switch address, on a press of a push-button key. The red LEDs continuously display the contents of the currently addressed location. This is a top-level board task with push-button key, slide-switch and LED I/O; it holds no other state.

## Interface
Parameters: none (depth 8, width 8, fixed).

Ports:
- clk  input  1  system clock; all state on rising edge.
- key0_rst  input  1  reset. One clock; reset is synchronous and active-high.
- key1_write  input  1  write key, active-low (0 = pressed), asynchronous to clk.
- sw_addr  input  3  location select for both write and display; asynchronous switches.
- sw_value  input  8  data to write; asynchronous switches.
- ledr_indic  output  8  registered contents of the location addressed by the synchronized sw_addr.

## Operation
- Storage: mem[0..7], 8 bits each, all cleared to 0 by reset.
- Input synchronization: key1_write, sw_addr and sw_value each pass through the same two-flop synchronizer (stages s1, s2), so all three stay cycle-aligned.
- Press detection: a third flop k3 holds the previous key_s2.
  - A write strobe is high for exactly one cycle when key_s2 = 0 and k3 = 1 (released→pressed edge).
- Write: on a strobe cycle, mem[addr_s2] <= value_s2.
  - One write per press, however long the key is held.
  - Changing switches while the key is held causes no further writes.
  - Releasing the key causes no write.
- Display: every cycle, ledr_indic <= mem[addr_s2].
  - Write-first: if the strobe targets addr_s2 in the same cycle, ledr_indic takes value_s2.
- Reset (key0_rst = 1 at a rising edge):
  - all mem entries → 0
  - ledr_indic → 0
  - key_s1, key_s2, k3 → 1 (released)
  - addr/value synchronizer stages → 0
  - Reset has priority over any write in the same cycle.
  - Because the key flops reset to the released state, a key held down through reset release produces one write after the synchronizer delay. This is the required behaviour.
- No wrap or overflow conditions: the address is full-range 0..7, and values are stored unmodified.

## Timing
- Switch-to-LED latency: a change on sw_addr appears on ledr_indic at the 3rd rising edge after the change is sampled (2 sync + 1 output register).
- Press-to-store latency: the memory is updated at the 3rd rising edge after the key falls, counted from the first sampling edge at which it is low.
- Write-to-display, same address: ledr_indic shows the new value at that same edge (write-first).
- Minimum key low time: 2 clock cycles for guaranteed detection. Shorter pulses may or may not be detected; if detected, they write once.
- sw_addr/sw_value must be stable from ≥2 cycles before the key falls until the write edge. Otherwise the stored pair is the one sampled in the strobe cycle.
- Reset takes effect at the first rising edge with key0_rst = 1.
  - Outputs read 0 from that edge until released.
  - Normal operation resumes on the first edge with key0_rst = 0.

## Test plan
- Reset → ledr_indic = 0 for every sw_addr 0..7. Reset asserted mid-write-press → no location is written; all reads return 0.
- Press key with addr=0, value=10; release; set addr=0 → ledr_indic = 10 after 3 cycles.
- Sequential presses write 10, 20, 30, 40, 50 to addr 0..4, with the key released (value=0, addr=0) between presses. Then sweep addr 1, 2, 3, 4 → 20, 30, 40, 50; addr 5..7 → 0; addr 0 → 10 (released key never writes 0).
- Hold key low 20 cycles at addr=6, value=0x55; change value to 0xAA mid-hold → mem[6] = 0x55; exactly one write strobe.
- Display addr=2 while pressing with addr=2, value=0xFF → ledr_indic goes 30 → 0xFF at the write edge, with no intermediate value.
- Write 0xFF to addr 7, then assert reset for 1 cycle → addr 7 reads 0; ledr_indic = 0 during reset.
